// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the profile-priority arbiter.
// State encoding, index-width helper and default parameters.
package arbitro_pkg;

  typedef enum logic [1:0] {
    LIVRE     = 2'd0,
    CONCEDIDO = 2'd1,
    TROCA     = 2'd2
  } estado_t;

  localparam int N_IF_DEF     = 4;
  localparam int PERFIL_W_DEF = 3;
  localparam int HOLD_MAX_DEF = 16;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_prioridade_if.sv
// Request/grant bundle between interface logic and the arbiter.
// master = requesters, slave = arbiter.
interface arbitro_prioridade_if
  import arbitro_pkg::*;
#(
  parameter int N_IF     = N_IF_DEF,
  parameter int PERFIL_W = PERFIL_W_DEF
);

  localparam int IDX_W = idx_w(N_IF);

  logic [N_IF-1:0]          req;
  logic [N_IF*PERFIL_W-1:0] perfil;
  logic [N_IF-1:0]          concede;
  logic [IDX_W-1:0]         concede_idx;
  logic                     ocupado;
  logic [PERFIL_W-1:0]      perfil_atual;
  logic                     preempcao;

  modport master (
    output req, perfil,
    input  concede, concede_idx, ocupado,
    input  perfil_atual, preempcao
  );

  modport slave (
    input  req, perfil,
    output concede, concede_idx, ocupado,
    output perfil_atual, preempcao
  );

endinterface

// File: rtl/arbitro_prioridade_seletor.sv
// Combinational winner search: max profile, round-robin tie break,
// plus strongest competitor other than the current owner.
module seletor_prioridade
  import arbitro_pkg::*;
#(
  parameter int N_IF     = N_IF_DEF,
  parameter int PERFIL_W = PERFIL_W_DEF,
  parameter int IDX_W    = idx_w(N_IF)
) (
  input  logic [N_IF-1:0]          req_i,
  input  logic [N_IF*PERFIL_W-1:0] perfil_i,
  input  logic [IDX_W-1:0]         rr_ptr_i,
  input  logic [IDX_W-1:0]         owner_i,
  output logic [IDX_W-1:0]         win_idx_o,
  output logic                     win_vld_o,
  output logic [PERFIL_W-1:0]      win_perfil_o,
  output logic                     comp_vld_o,
  output logic [PERFIL_W-1:0]      comp_max_o
);

  logic [PERFIL_W-1:0] pf [N_IF];
  logic [PERFIL_W-1:0] max_p;
  logic                found;

  always_comb begin
    for (int i = 0; i < N_IF; i++)
      pf[i] = perfil_i[i*PERFIL_W +: PERFIL_W];
  end

  always_comb begin
    max_p      = '0;
    win_vld_o  = 1'b0;
    comp_vld_o = 1'b0;
    comp_max_o = '0;
    for (int i = 0; i < N_IF; i++) begin
      if (req_i[i]) begin
        win_vld_o = 1'b1;
        if (pf[i] > max_p)
          max_p = pf[i];
        if (IDX_W'(i) != owner_i) begin
          comp_vld_o = 1'b1;
          if (pf[i] > comp_max_o)
            comp_max_o = pf[i];
        end
      end
    end
  end

  // search starts just after the last owner, wrapping around
  always_comb begin
    found     = 1'b0;
    win_idx_o = '0;
    for (int k = 1; k <= N_IF; k++) begin
      int j;
      j = int'(rr_ptr_i) + k;
      if (j >= N_IF)
        j = j - N_IF;
      if (!found && req_i[j] && pf[j] == max_p) begin
        found     = 1'b1;
        win_idx_o = IDX_W'(j);
      end
    end
  end

  assign win_perfil_o = max_p;

endmodule

// File: rtl/arbitro_prioridade.sv
// Profile-priority arbiter: grant/hold/release FSM with round-robin
// tie break, hold-limit preemption and a one-cycle turnaround gap.
module arbitro_prioridade
  import arbitro_pkg::*;
#(
  parameter int N_IF     = N_IF_DEF,
  parameter int PERFIL_W = PERFIL_W_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  arbitro_prioridade_if.slave bus
);

  localparam int IDX_W = idx_w(N_IF);
  localparam int HC_W  = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HC_W-1:0] HOLD_LIM =
    (HOLD_MAX == 0) ? {HC_W{1'b1}} : HC_W'(HOLD_MAX - 1);
  localparam logic [N_IF-1:0] ONE = N_IF'(1);

  estado_t             state_q;
  logic [N_IF-1:0]     concede_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    rr_q;
  logic [PERFIL_W-1:0] perfil_q;
  logic                preempt_q;
  logic [HC_W-1:0]     hold_q;

  logic [IDX_W-1:0]    win_idx;
  logic                win_vld;
  logic [PERFIL_W-1:0] win_perfil;
  logic                comp_vld;
  logic [PERFIL_W-1:0] comp_max;
  logic                owner_req;
  logic                preempt_ok;

  seletor_prioridade #(
    .N_IF     (N_IF),
    .PERFIL_W (PERFIL_W),
    .IDX_W    (IDX_W)
  ) u_sel (
    .req_i        (bus.req),
    .perfil_i     (bus.perfil),
    .rr_ptr_i     (rr_q),
    .owner_i      (idx_q),
    .win_idx_o    (win_idx),
    .win_vld_o    (win_vld),
    .win_perfil_o (win_perfil),
    .comp_vld_o   (comp_vld),
    .comp_max_o   (comp_max)
  );

  assign owner_req  = bus.req[idx_q];
  assign preempt_ok = (HOLD_MAX != 0) && (hold_q == HOLD_LIM) &&
                      comp_vld && (comp_max >= perfil_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LIVRE;
      concede_q <= '0;
      idx_q     <= '0;
      rr_q      <= IDX_W'(N_IF - 1);
      perfil_q  <= '0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      preempt_q <= 1'b0;
      unique case (state_q)
        LIVRE, TROCA: begin
          if (win_vld) begin
            state_q   <= CONCEDIDO;
            concede_q <= ONE << win_idx;
            idx_q     <= win_idx;
            rr_q      <= win_idx;
            perfil_q  <= win_perfil;
            hold_q    <= '0;
          end else begin
            state_q   <= LIVRE;
            concede_q <= '0;
          end
        end
        CONCEDIDO: begin
          // release takes precedence over preemption
          if (!owner_req) begin
            state_q   <= TROCA;
            concede_q <= '0;
          end else if (preempt_ok) begin
            state_q   <= TROCA;
            concede_q <= '0;
            preempt_q <= 1'b1;
          end else if (hold_q != HOLD_LIM) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q   <= LIVRE;
          concede_q <= '0;
        end
      endcase
    end
  end

  assign bus.concede      = concede_q;
  assign bus.concede_idx  = idx_q;
  assign bus.ocupado      = (state_q == CONCEDIDO);
  assign bus.perfil_atual = perfil_q;
  assign bus.preempcao    = preempt_q;

endmodule

// File: tb/tb_arbitro_prioridade.sv
// Directed and randomized checks of arbitro_prioridade against a
// behavioural model (N_IF=4, PERFIL_W=3, HOLD_MAX=4).
module tb_arbitro_prioridade;

  localparam int N   = 4;
  localparam int PW  = 3;
  localparam int HMX = 4;

  logic clk;
  logic rst;
  logic [N-1:0]  req;
  logic [PW-1:0] pf [N];

  int tests;
  int fails;

  int          m_st;
  int          m_idx;
  int          m_perf;
  int          m_hold;
  int          m_rr;
  logic [N-1:0] m_conc;
  logic        m_pre;

  arbitro_prioridade_if #(.N_IF(N), .PERFIL_W(PW)) bus ();

  assign bus.req    = req;
  assign bus.perfil = {pf[3], pf[2], pf[1], pf[0]};

  arbitro_prioridade #(
    .N_IF     (N),
    .PERFIL_W (PW),
    .HOLD_MAX (HMX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // highest profile among requesters; ties go to first index after m_rr
  function automatic int ref_winner();
    int best;
    int j;
    best = -1;
    for (int i = 0; i < N; i++)
      if (req[i] && int'(pf[i]) > best) best = int'(pf[i]);
    for (int k = 1; k <= N; k++) begin
      j = (m_rr + k) % N;
      if (req[j] && int'(pf[j]) == best) return j;
    end
    return -1;
  endfunction

  function automatic bit ref_challenger();
    for (int i = 0; i < N; i++)
      if (i != m_idx && req[i] && int'(pf[i]) >= m_perf) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mdl_edge();
    int w;
    if (rst) begin
      m_st = 0; m_conc = '0; m_idx = 0; m_perf = 0;
      m_hold = 0; m_rr = N - 1; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_st != 1) begin
        w = ref_winner();
        if (w >= 0) begin
          m_st = 1; m_conc = 4'(1 << w); m_idx = w;
          m_perf = int'(pf[w]); m_rr = w; m_hold = 0;
        end else begin
          m_st = 0; m_conc = '0;
        end
      end else if (!req[m_idx]) begin
        m_st = 2; m_conc = '0;
      end else if (m_hold == HMX - 1 && ref_challenger()) begin
        m_st = 2; m_conc = '0; m_pre = 1'b1;
      end else if (m_hold < HMX - 1) begin
        m_hold++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_edge();
    #1;
    chk("concede", 32'(bus.concede), 32'(m_conc));
    chk("ocupado", 32'(bus.ocupado), 32'(m_conc != 0));
    chk("preempcao", 32'(bus.preempcao), 32'(m_pre));
    if (m_conc != 0) begin
      chk("concede_idx", 32'(bus.concede_idx), 32'(m_idx));
      chk("perfil_atual", 32'(bus.perfil_atual), 32'(m_perf));
    end
  endtask

  task automatic wait_grant(input string tag);
    int n;
    tick();
    n = 1;
    while (!bus.ocupado && n < 6) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.ocupado), 32'd1);
  endtask

  task automatic idle2();
    req = '0;
    tick();
    tick();
  endtask

  initial begin
    int exp_ord [5];
    int o;
    exp_ord = '{0, 1, 2, 3, 0};
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) pf[i] = '0;
    m_st = 0; m_conc = '0; m_idx = 0; m_perf = 0;
    m_hold = 0; m_rr = N - 1; m_pre = 1'b0;
    tick();
    tick();
    chk("rst_concede", 32'(bus.concede), 32'd0);
    chk("rst_idx", 32'(bus.concede_idx), 32'd0);
    chk("rst_perfil", 32'(bus.perfil_atual), 32'd0);
    rst = 1'b0;

    // four-way tie rotates 0,1,2,3,0
    for (int i = 0; i < N; i++) pf[i] = 3'd2;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant("tie_wait");
      chk("tie_order", 32'(bus.concede_idx), 32'(exp_ord[g]));
      o = int'(bus.concede_idx);
      tick();
      req[o] = 1'b0;
      tick();
      chk("tie_gap", 32'(bus.concede), 32'd0);
      req[o] = 1'b1;
    end
    idle2();

    // higher profile wins; a later stronger request waits for hold limit
    pf[1] = 3'd1;
    pf[2] = 3'd5;
    req = 4'b0110;
    tick();
    chk("prio_grant", 32'(bus.concede), 32'b0100);
    chk("prio_perfil", 32'(bus.perfil_atual), 32'd5);
    pf[3] = 3'd7;
    req = 4'b1110;
    repeat (3) begin
      tick();
      chk("prio_hold", 32'(bus.concede), 32'b0100);
    end
    tick();
    chk("prio_pre", 32'(bus.preempcao), 32'd1);
    tick();
    chk("prio_next", 32'(bus.concede), 32'b1000);
    idle2();

    // equal-profile competitor preempts after 4 grant cycles
    pf[0] = 3'd3;
    req = 4'b0001;
    tick();
    chk("pre_grant", 32'(bus.concede), 32'b0001);
    pf[2] = 3'd3;
    req = 4'b0101;
    repeat (3) begin
      tick();
      chk("pre_hold", 32'(bus.concede), 32'b0001);
    end
    tick();
    chk("pre_pulse", 32'(bus.preempcao), 32'd1);
    chk("pre_gap", 32'(bus.concede), 32'd0);
    tick();
    chk("pre_new", 32'(bus.concede), 32'b0100);
    chk("pre_pulse_end", 32'(bus.preempcao), 32'd0);
    idle2();

    // lone requester keeps the grant indefinitely
    req = 4'b0010;
    tick();
    repeat (20) begin
      tick();
      chk("solo_hold", 32'(bus.concede), 32'b0010);
      chk("solo_nopre", 32'(bus.preempcao), 32'd0);
    end

    // reset mid-grant, then first grants after reset
    rst = 1'b1;
    tick();
    chk("mid_rst_concede", 32'(bus.concede), 32'd0);
    chk("mid_rst_ocupado", 32'(bus.ocupado), 32'd0);
    chk("mid_rst_idx", 32'(bus.concede_idx), 32'd0);
    chk("mid_rst_perfil", 32'(bus.perfil_atual), 32'd0);
    rst = 1'b0;
    req = 4'b1000;
    tick();
    chk("post_rst_grant", 32'(bus.concede), 32'b1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) pf[i] = 3'd2;
    req = 4'b1111;
    tick();
    chk("post_rst_tie", 32'(bus.concede), 32'b0001);
    idle2();

    // latched owner profile; release coinciding with hold limit
    pf[0] = 3'd2;
    req = 4'b0001;
    tick();
    pf[0] = 3'd7;
    pf[1] = 3'd2;
    req = 4'b0011;
    tick();
    chk("latch_perfil", 32'(bus.perfil_atual), 32'd2);
    tick();
    tick();
    req = 4'b0010;
    tick();
    chk("simul_nopre", 32'(bus.preempcao), 32'd0);
    chk("simul_gap", 32'(bus.concede), 32'd0);
    tick();
    chk("simul_next", 32'(bus.concede), 32'b0010);
    idle2();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) begin
        req = 4'($urandom_range(0, 15));
        for (int i = 0; i < N; i++) pf[i] = 3'($urandom_range(0, 7));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
